// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble logic.
// Ports: ID bundle in, EX/MEM and MEM/WB bypass in, ALU operands and EX controls out.

package ex_operand_pkg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic        src_b_imm;
    logic        src_a_shamt;
    logic        regwrite;
    logic        memread;
  } id_ex_t;

endpackage

module ex_operand_stage
  import ex_operand_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic [4:0]             id_wa,
  input  logic [31:0]            id_rs_val,
  input  logic [31:0]            id_rt_val,
  input  logic [31:0]            id_imm,
  input  logic [4:0]             id_shamt,
  input  logic [4:0]             id_aluop,
  input  logic                   id_src_b_imm,
  input  logic                   id_src_a_shamt,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   hold_in,
  input  logic                   flush_in,
  input  logic                   exm_regwrite,
  input  logic [4:0]             exm_wa,
  input  logic [31:0]            exm_data,
  input  logic                   wb_regwrite,
  input  logic [4:0]             wb_wa,
  input  logic [31:0]            wb_data,
  output logic                   ex_valid,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [4:0]             alu_op,
  output logic [31:0]            ex_store_data,
  output logic [4:0]             ex_wa,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   lu_stall,
  output logic [STALL_CNT_W-1:0] bubble_cnt
);

  id_ex_t                 ex_q;
  id_ex_t                 ex_d;
  id_ex_t                 id_pkt;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;

  logic wb_hit_rs_id;
  logic wb_hit_rt_id;
  logic do_flush;
  logic do_hold;
  logic do_stall;
  logic do_load;

  logic exm_hit_rs;
  logic exm_hit_rt;
  logic wb_hit_rs;
  logic wb_hit_rt;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // A write-back in flight this cycle has not reached the register
  // file read ID saw, so it is folded in as the value is captured.
  assign wb_hit_rs_id = wb_regwrite && (wb_wa != 5'd0)
                        && (wb_wa == id_rs);
  assign wb_hit_rt_id = wb_regwrite && (wb_wa != 5'd0)
                        && (wb_wa == id_rt);

  always_comb begin
    id_pkt             = '0;
    id_pkt.valid       = id_valid;
    id_pkt.rs          = id_rs;
    id_pkt.rt          = id_rt;
    id_pkt.wa          = id_wa;
    id_pkt.rs_val      = wb_hit_rs_id ? wb_data : id_rs_val;
    id_pkt.rt_val      = wb_hit_rt_id ? wb_data : id_rt_val;
    id_pkt.imm         = id_imm;
    id_pkt.shamt       = id_shamt;
    id_pkt.aluop       = id_aluop;
    id_pkt.src_b_imm   = id_src_b_imm;
    id_pkt.src_a_shamt = id_src_a_shamt;
    id_pkt.regwrite    = id_regwrite;
    id_pkt.memread     = id_memread;
  end

  // Consumer in ID needs a load that is still in EX: data is not
  // available until MEM/WB, so one bubble is enough.
  assign lu_stall = id_valid && ex_q.valid && ex_q.memread
                    && (ex_q.wa != 5'd0)
                    && ((id_use_rs && (id_rs == ex_q.wa))
                     || (id_use_rt && (id_rt == ex_q.wa)));

  // Priority flattened into one-hot selects.
  assign do_flush = flush_in;
  assign do_hold  = !flush_in && hold_in;
  assign do_stall = !flush_in && !hold_in && lu_stall;
  assign do_load  = !flush_in && !hold_in && !lu_stall;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      do_flush: ex_d = '0;
      do_hold:  ex_d = ex_q;
      do_stall: begin
        ex_d = '0;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end
      do_load:  ex_d = id_pkt;
      default:  ex_d = ex_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign exm_hit_rs = exm_regwrite && (exm_wa != 5'd0)
                      && (exm_wa == ex_q.rs);
  assign exm_hit_rt = exm_regwrite && (exm_wa != 5'd0)
                      && (exm_wa == ex_q.rt);
  assign wb_hit_rs  = wb_regwrite && (wb_wa != 5'd0)
                      && (wb_wa == ex_q.rs);
  assign wb_hit_rt  = wb_regwrite && (wb_wa != 5'd0)
                      && (wb_wa == ex_q.rt);

  // Youngest producer wins.
  always_comb begin
    fwd_rs = ex_q.rs_val;
    if (exm_hit_rs)     fwd_rs = exm_data;
    else if (wb_hit_rs) fwd_rs = wb_data;
  end

  always_comb begin
    fwd_rt = ex_q.rt_val;
    if (exm_hit_rt)     fwd_rt = exm_data;
    else if (wb_hit_rt) fwd_rt = wb_data;
  end

  assign alu_a = ex_q.src_a_shamt ? {27'b0, ex_q.shamt} : fwd_rs;
  assign alu_b = ex_q.src_b_imm ? ex_q.imm : fwd_rt;

  assign ex_store_data = fwd_rt;
  assign ex_valid      = ex_q.valid;
  assign alu_op        = ex_q.aluop;
  assign ex_wa         = ex_q.wa;
  assign ex_regwrite   = ex_q.valid && ex_q.regwrite;
  assign ex_memread    = ex_q.valid && ex_q.memread;
  assign bubble_cnt    = cnt_q;

endmodule
